timer_host_master: RTL



---
 rtl/timer_host_master.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_host_master.sv
// timer_host_master
// Avalon-MM master that programs and services a 16-bit-data interval timer
// slave for a local controller. It turns start/stop/snapshot command pulses
// into timer register writes and reads, detects timeouts (timer IRQ or status
// polling), clears them and reports each serviced timeout as a tick.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   cmd_start/stop/snap command pulses, accepted only in IDLE or RUN
//   cfg_period          timer period in clk cycles (sampled at cmd_start)
//   cfg_continuous      1=periodic, 0=one-shot (sampled at cmd_start)
//   cfg_irq_en          1=timer_irq detects timeouts, 0=status polling
//   busy                high whenever a bus sequence is in progress
//   tick, tick_count    serviced-timeout pulse and counter
//   snap_valid/value    snapshot result pulse and captured counter value
//   cmd_err             pulse when cmd_start is rejected (period 0)
//   avm_*               Avalon-MM master towards the timer slave
//   timer_irq           timer interrupt input
module timer_host_master #(
    parameter int POLL_INTERVAL = 16,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               cmd_snap,
    input  logic [31:0]        cfg_period,
    input  logic               cfg_continuous,
    input  logic               cfg_irq_en,
    output logic               busy,
    output logic               tick,
    output logic [COUNT_W-1:0] tick_count,
    output logic               snap_valid,
    output logic [31:0]        snap_value,
    output logic               cmd_err,
    output logic [2:0]         avm_address,
    output logic               avm_chipselect,
    output logic               avm_write_n,
    output logic [15:0]        avm_writedata,
    input  logic [15:0]        avm_readdata,
    input  logic               timer_irq
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W_STOP  = 4'd1,
        W_PL    = 4'd2,
        W_PH    = 4'd3,
        W_CTRL  = 4'd4,
        RUN     = 4'd5,
        POLL_A  = 4'd6,
        POLL_D  = 4'd7,
        W_CLR   = 4'd8,
        W_STOP2 = 4'd9,
        W_CLR2  = 4'd10,
        W_SNAP  = 4'd11,
        R_SL    = 4'd12,
        R_SH    = 4'd13,
        R_SD    = 4'd14
    } state_t;

    localparam logic [2:0]  REG_STATUS = 3'd0;
    localparam logic [2:0]  REG_CTRL   = 3'd1;
    localparam logic [2:0]  REG_PER_L  = 3'd2;
    localparam logic [2:0]  REG_PER_H  = 3'd3;
    localparam logic [2:0]  REG_SNAP_L = 3'd4;
    localparam logic [2:0]  REG_SNAP_H = 3'd5;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [15:0] POLL_LAST  = 16'(POLL_INTERVAL - 1);

    state_t        state_r;
    logic [31:0]   period_m1_r;
    logic          cont_r;
    logic          irq_en_r;
    logic          snap_from_run_r;
    logic [15:0]   poll_cnt_r;
    logic [15:0]   snap_lo_r;

    // Control register word: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
    function automatic logic [15:0] ctrl_word(input logic start, input logic cont,
                                              input logic ito);
        return {12'h000, 1'b0, start, cont, ito};
    endfunction

    // Command FSM; every output is a register loaded on entry to the state
    // in which it must be visible, so a write state drives the bus for
    // exactly its one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            period_m1_r     <= 32'h0000_0000;
            cont_r          <= 1'b0;
            irq_en_r        <= 1'b0;
            snap_from_run_r <= 1'b0;
            poll_cnt_r      <= 16'h0000;
            snap_lo_r       <= 16'h0000;
            busy            <= 1'b0;
            tick            <= 1'b0;
            tick_count      <= '0;
            snap_valid      <= 1'b0;
            snap_value      <= 32'h0000_0000;
            cmd_err         <= 1'b0;
            avm_address     <= 3'd0;
            avm_chipselect  <= 1'b0;
            avm_write_n     <= 1'b1;
            avm_writedata   <= 16'h0000;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            tick           <= 1'b0;
            snap_valid     <= 1'b0;
            cmd_err        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_start) begin
                        if (cfg_period == 32'h0000_0000) begin
                            cmd_err <= 1'b1;
                        end else begin
                            period_m1_r    <= cfg_period - 32'd1;
                            cont_r         <= cfg_continuous;
                            irq_en_r       <= cfg_irq_en;
                            tick_count     <= '0;
                            avm_chipselect <= 1'b1;
                            avm_write_n    <= 1'b0;
                            avm_address    <= REG_CTRL;
                            avm_writedata  <= CTRL_STOP;
                            busy           <= 1'b1;
                            state_r        <= W_STOP;
                        end
                    end else if (cmd_snap) begin
                        snap_from_run_r <= 1'b0;
                        avm_chipselect  <= 1'b1;
                        avm_write_n     <= 1'b0;
                        avm_address     <= REG_SNAP_L;
                        avm_writedata   <= 16'h0000;
                        busy            <= 1'b1;
                        state_r         <= W_SNAP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                W_STOP: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= REG_PER_L;
                    avm_writedata  <= period_m1_r[15:0];
                    state_r        <= W_PL;
                end
                W_PL: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= REG_PER_H;
                    avm_writedata  <= period_m1_r[31:16];
                    state_r        <= W_PH;
                end
                W_PH: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= REG_CTRL;
                    avm_writedata  <= ctrl_word(1'b1, cont_r, irq_en_r);
                    state_r        <= W_CTRL;
                end
                W_CTRL: begin
                    poll_cnt_r <= 16'h0000;
                    busy       <= 1'b0;
                    state_r    <= RUN;
                end
                RUN: begin
                    // Stop wins over a timeout, a timeout wins over a snapshot.
                    if (cmd_stop) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_CTRL;
                        avm_writedata  <= CTRL_STOP;
                        busy           <= 1'b1;
                        state_r        <= W_STOP2;
                    end else if (irq_en_r && timer_irq) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_STATUS;
                        avm_writedata  <= 16'h0000;
                        tick           <= 1'b1;
                        tick_count     <= tick_count + 1'b1;
                        busy           <= 1'b1;
                        state_r        <= W_CLR;
                    end else if (cmd_snap) begin
                        snap_from_run_r <= 1'b1;
                        avm_chipselect  <= 1'b1;
                        avm_write_n     <= 1'b0;
                        avm_address     <= REG_SNAP_L;
                        avm_writedata   <= 16'h0000;
                        busy            <= 1'b1;
                        state_r         <= W_SNAP;
                    end else if (!irq_en_r && (poll_cnt_r >= POLL_LAST)) begin
                        // poll_cnt_r counts cycles since the last poll began
                        poll_cnt_r  <= 16'h0000;
                        avm_address <= REG_STATUS;
                        busy        <= 1'b1;
                        state_r     <= POLL_A;
                    end else begin
                        poll_cnt_r <= poll_cnt_r + 16'd1;
                        state_r    <= RUN;
                    end
                end
                POLL_A: begin
                    poll_cnt_r <= poll_cnt_r + 16'd1;
                    state_r    <= POLL_D;
                end
                POLL_D: begin
                    poll_cnt_r <= poll_cnt_r + 16'd1;
                    if (avm_readdata[0]) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= REG_STATUS;
                        avm_writedata  <= 16'h0000;
                        tick           <= 1'b1;
                        tick_count     <= tick_count + 1'b1;
                        state_r        <= W_CLR;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                W_CLR: begin
                    // timer_irq is still high here; it is next looked at in RUN
                    busy    <= 1'b0;
                    state_r <= cont_r ? RUN : IDLE;
                end
                W_STOP2: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= REG_STATUS;
                    avm_writedata  <= 16'h0000;
                    state_r        <= W_CLR2;
                end
                W_CLR2: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                W_SNAP: begin
                    avm_address <= REG_SNAP_L;
                    state_r     <= R_SL;
                end
                R_SL: begin
                    avm_address <= REG_SNAP_H;
                    state_r     <= R_SH;
                end
                R_SH: begin
                    // readdata now holds snap_l (slave latency of one cycle)
                    snap_lo_r <= avm_readdata;
                    state_r   <= R_SD;
                end
                R_SD: begin
                    snap_value <= {avm_readdata, snap_lo_r};
                    snap_valid <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= snap_from_run_r ? RUN : IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
